// File: rtl/load_store_unit.sv
// Purpose: RV32I load/store stage driving a word-wide single-port RAM, with read-modify-write for SB/SH.
// Latency: accept->resp_valid is 2 cycles for loads, SW and faults, and 3 cycles for SB/SH.
// Backpressure: req_ready is high only in IDLE; resp_valid is a one-cycle pulse with no backpressure.
// Optional feature: define MISALIGN_TRAP_EN to fault misaligned LH/LHU/SH/LW/SW instead of ignoring low bits.
module load_store_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    we_q;
    logic [2:0]              funct3_q;
    logic [ADDR_WIDTH+1:0]   addr_q;     // only the bits that reach the RAM or select a lane
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   merge_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    fault_q;

    logic                    illegal;
    logic                    misalign;
    logic                    fault;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   load_ext;
    logic [DATA_WIDTH-1:0]   merged;

    assign mem_addr = addr_q[ADDR_WIDTH+1:2];

    // Classify the latched request: unsupported funct3, plus optional alignment trap
    always_comb begin
        illegal  = we_q ? (funct3_q > 3'd2)
                        : ((funct3_q == 3'd3) || (funct3_q > 3'd5));
`ifdef MISALIGN_TRAP_EN
        misalign = ((funct3_q[1:0] == 2'd1) && addr_q[0]) ||
                   ((funct3_q[1:0] == 2'd2) && (addr_q[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        fault    = illegal || misalign;
    end

    // Pick the addressed lane from the RAM word and extend it to a full register value
    always_comb begin
        ld_byte  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half  = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_ext = '0;
        case (funct3_q)
            3'd0:    load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    load_ext = {{16{ld_half[15]}}, ld_half};
            3'd2:    load_ext = mem_rdata;
            3'd4:    load_ext = {24'd0, ld_byte};
            3'd5:    load_ext = {16'd0, ld_half};
            default: load_ext = '0;
        endcase
    end

    // Overlay the store lane onto the word read back during ACCESS
    always_comb begin
        merged = merge_q;
        if (funct3_q[0] == 1'b0) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Next-state and RAM/handshake outputs; RAM writes are blocked whenever rst is high
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ACCESS;
            end
            ACCESS: begin
                if (we_q && !fault && (funct3_q != 3'd2)) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                end
                if (we_q && !fault && (funct3_q == 3'd2)) mem_we = !rst;
            end
            WRITE: begin
                mem_we    = !rst;
                mem_wdata = merged;
                state_d   = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, request capture and ACCESS-cycle result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && req_valid) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[ADDR_WIDTH+1:0];
                wdata_q  <= req_wdata;
            end
            if (state_q == ACCESS) begin
                fault_q <= fault;
                rdata_q <= (!we_q && !fault) ? load_ext : '0;
                merge_q <= mem_rdata;
            end
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign resp_fault = (state_q == RESP) ? fault_q : 1'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: exercise load_store_unit against a word-array reference model with directed and random traffic.
// Latency: the bench measures accept->resp_valid in cycles and compares it with the model.
// Backpressure: the bench holds req_valid while req_ready is low and checks acceptance only in IDLE.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        init_we;
    logic [9:0]  init_idx;
    logic [31:0] init_dat;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] obs_rdata;
    logic        obs_fault;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Data RAM: asynchronous read, synchronous whole-word write, plus a preload port
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (init_we) ram[init_idx] <= init_dat;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model: byte-addressed view of a word array; updates ref_mem for stores
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] er, output logic ef,
                         output int elat, output int ewes);
        int               idx, bsh, hsh;
        logic [31:0]      w, mask, data;
        logic             illegal, mis;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        idx = int'((addr / 4) % 1024);
        w   = ref_mem[idx];
        bsh = int'(addr % 4) * 8;
        hsh = int'((addr / 2) % 2) * 16;
        illegal = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 > 3'd5));
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (f3 == 3'd1 || f3 == 3'd5) mis = (addr % 2) != 0;
        if (f3 == 3'd2) mis = (addr % 4) != 0;
`endif
        er = 32'd0; ef = illegal || mis; elat = 2; ewes = 0;
        if (!ef) begin
            if (!we) begin
                sb = 8'(w >> bsh);
                sh = 16'(w >> hsh);
                case (f3)
                    3'd0: er = int'(sb);
                    3'd1: er = int'(sh);
                    3'd2: er = w;
                    3'd4: er = (w >> bsh) & 32'hFF;
                    default: er = (w >> hsh) & 32'hFFFF;
                endcase
            end else begin
                ewes = 1;
                if (f3 == 3'd2) begin
                    ref_mem[idx] = wd;
                end else begin
                    elat = 3;
                    mask = (f3 == 3'd0) ? (32'hFF << bsh) : (32'hFFFF << hsh);
                    data = (f3 == 3'd0) ? ((wd & 32'hFF) << bsh) : ((wd & 32'hFFFF) << hsh);
                    ref_mem[idx] = (w & ~mask) | data;
                end
            end
        end
    endtask

    // One complete request: issue, wait (bounded) for the response, compare with the model
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        logic [31:0] er;
        logic        ef;
        int          elat, ewes, lat, wes;
        logic        got;
        model(we, f3, addr, wd, er, ef, elat, ewes);
        @(negedge clk);
        check_eq("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        lat = 0; wes = 0; got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (mem_we) wes++;
            if (resp_valid) begin
                got = 1'b1;
                obs_rdata = resp_rdata;
                obs_fault = resp_fault;
            end
        end
        check_eq("resp_seen", 32'(got), 32'd1);
        check_eq("rdata", obs_rdata, er);
        check_eq("fault", 32'(obs_fault), 32'(ef));
        check_eq("latency", 32'(lat), 32'(elat));
        check_eq("mem_we_pulses", 32'(wes), 32'(ewes));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        init_we = 1'b0; init_idx = 10'd0; init_dat = 32'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'h003100B3;
        ref_mem[1] = 32'h11223344;

        // Preload the words the traffic touches while held in reset
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            init_we = 1'b1; init_idx = 10'(i); init_dat = ref_mem[i];
        end
        @(negedge clk);
        init_we = 1'b0;
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_fault", 32'(resp_fault), 32'd0);
        check_eq("rst_resp_rdata", resp_rdata, 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        rst = 1'b0;

        // Loads from word0 with sign/zero extension
        run_txn(1'b0, 3'd0, 32'd0, 32'd0); check_eq("lb0", obs_rdata, 32'hFFFFFFB3);
        run_txn(1'b0, 3'd4, 32'd0, 32'd0); check_eq("lbu0", obs_rdata, 32'h000000B3);
        run_txn(1'b0, 3'd1, 32'd2, 32'd0); check_eq("lh2", obs_rdata, 32'h00000031);
        run_txn(1'b0, 3'd2, 32'd0, 32'd0); check_eq("lw0", obs_rdata, 32'h003100B3);

        // Sub-word stores via read-modify-write
        run_txn(1'b1, 3'd0, 32'd5, 32'hFFFFFFAB); check_eq("sb5_word1", ram[1], 32'h1122AB44);
        run_txn(1'b1, 3'd1, 32'd6, 32'h0000BEEF); check_eq("sh6_word1", ram[1], 32'hBEEFAB44);

        // SW then LW with req_valid held high across the busy window
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'd8; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        ref_mem[2] = 32'hDEADBEEF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check_eq("held_ready", 32'(req_ready), (c == 3) ? 32'd1 : 32'd0);
            check_eq("held_resp_valid", 32'(resp_valid), (c == 2 || c == 5) ? 32'd1 : 32'd0);
            if (c == 2) check_eq("held_sw_rdata", resp_rdata, 32'd0);
            if (c == 5) check_eq("held_lw_rdata", resp_rdata, 32'hDEADBEEF);
            if (c == 1) req_we = 1'b0;
            if (c == 4) req_valid = 1'b0;
        end

        // Illegal funct3: faults without touching memory
        run_txn(1'b0, 3'd3, 32'd0, 32'd0); check_eq("ld_f3_3_fault", 32'(obs_fault), 32'd1);
        run_txn(1'b1, 3'd5, 32'd0, 32'h12345678); check_eq("st_f3_5_word0", ram[0], 32'h003100B3);

        // Misaligned LW
        run_txn(1'b0, 3'd2, 32'd2, 32'd0);
`ifdef MISALIGN_TRAP_EN
        check_eq("lw2_trap", 32'(obs_fault), 32'd1);
`else
        check_eq("lw2_word0", obs_rdata, 32'h003100B3);
`endif

        // Reset during the WRITE cycle of SB @0
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("write_cycle_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_blocks_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        check_eq("rst_mid_ready", 32'(req_ready), 32'd1);
        check_eq("rst_mid_resp", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("rst_mid_no_resp", 32'(resp_valid), 32'd0);
        end
        check_eq("rst_mid_word0", ram[0], 32'h003100B3);

        // Random traffic over 16 words, with random upper address bits that must wrap away
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 16; i++) check_eq("ram_final", ram[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
